// File: rtl/fm_diag_arb_pkg.sv
// Shared definitions for the FM diagnostic arbiter.
// Contents: the sequencer state enum, the latched diagnostic command, the
// starve counter width and the AR-from-EBUS select code driven onto
// ar_load_ebus.
package fm_diag_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOLD = 3'd1,
    LDAR = 3'd2,
    WRFM = 3'd3,
    RDAD = 3'd4,
    DONE = 3'd5
  } fmDiagStateT;

  typedef struct packed {
    logic       write;
    logic [2:0] block;
    logic [3:0] adr;
  } fm_diag_cmd_t;

  localparam int STARVE_W = 4;

  // CTL select that gates EBUS into ARL/ARR and loads all of AR.
  localparam logic AR_SEL_EBUS = 1'b1;

endpackage

// File: rtl/fm_starve_ctr.sv
// Saturating starve counter for the FM diagnostic arbiter.
// Counts cycles in which a pending diagnostic request loses to EBOX.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clr       clear to 0 (wins over inc)
//   inc       increment, saturating at LIMIT
//   at_limit  count equals LIMIT
module fm_starve_ctr
  import fm_diag_arb_pkg::*;
#(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(LIMIT);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                         cnt_d = '0;
    else if (inc && cnt_q != LIMIT_C) cnt_d = cnt_q + STARVE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign at_limit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/fm_diag_arb.sv
// FM write-port / AD->EBUS arbiter between EBOX microcode and the
// diagnostic EBUS port. In IDLE the EBOX FM controls pass straight through;
// an accepted diagnostic access stalls EBOX and steps the EDP through
//   write: HOLD -> LDAR (AR <- EBUS) -> WRFM (FM <- AR) -> DONE
//   read : HOLD -> RDAD (FM -> AD -> EBUS, captured)     -> DONE
// Optional build macro FM_DIAG_STARVE_EN: a starve counter forces the
// diagnostic access in after STARVE_LIMIT lost cycles, suppressing the
// EBOX write in that cycle. Without it EBOX always wins.
// Ports:
//   clk, CROBAR                 clock, synchronous active-high reset
//   ebox_req/block/adr/wr_l/wr_r microcode FM write request
//   ebox_hold                   stall EBOX (HOLD..DONE)
//   diag_req/write/block/adr    diagnostic command
//   diag_ack/busy/rdata         completion pulse, in-progress, read data
//   ebus_data                   EBUS data in
//   fm_block/adr/write00_17/18_35 FM controls to EDP
//   ar_load_ebus, ad_sel_fm, ad_to_ebus_l/r  EDP CTL selects
module fm_diag_arb
  import fm_diag_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 15
) (
  input  logic        clk,
  input  logic        CROBAR,
  input  logic        ebox_req,
  input  logic [2:0]  ebox_block,
  input  logic [3:0]  ebox_adr,
  input  logic        ebox_wr_l,
  input  logic        ebox_wr_r,
  output logic        ebox_hold,
  input  logic        diag_req,
  input  logic        diag_write,
  input  logic [2:0]  diag_block,
  input  logic [3:0]  diag_adr,
  output logic        diag_ack,
  output logic        diag_busy,
  output logic [0:35] diag_rdata,
  input  logic [0:35] ebus_data,
  output logic [2:0]  fm_block,
  output logic [3:0]  fm_adr,
  output logic        fm_write00_17,
  output logic        fm_write18_35,
  output logic        ar_load_ebus,
  output logic        ad_sel_fm,
  output logic        ad_to_ebus_l,
  output logic        ad_to_ebus_r
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("fm_diag_arb: STARVE_LIMIT must be in 1..15");
  end

  fmDiagStateT  state_q, state_d;
  fm_diag_cmd_t cmd_q, cmd_d;
  logic [0:35]  rdata_q, rdata_d;
  logic         idle, force_acc, accept;

  assign idle = (state_q == IDLE);

`ifdef FM_DIAG_STARVE_EN
  logic contend, at_limit;
  assign contend = idle & diag_req & ebox_req;

  // Cleared whenever the request goes away or is taken; counts lost cycles.
  fm_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve_ctr (
    .clk      (clk),
    .rst      (CROBAR),
    .clr      (idle & (~diag_req | accept)),
    .inc      (contend),
    .at_limit (at_limit)
  );
  assign force_acc = contend & at_limit;
`else
  assign force_acc = 1'b0;
`endif

  assign accept = idle & diag_req & (~ebox_req | force_acc);

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    rdata_d       = rdata_q;
    fm_block      = cmd_q.block;
    fm_adr        = cmd_q.adr;
    fm_write00_17 = 1'b0;
    fm_write18_35 = 1'b0;
    ar_load_ebus  = 1'b0;
    ad_sel_fm     = 1'b0;
    ad_to_ebus_l  = 1'b0;
    ad_to_ebus_r  = 1'b0;
    diag_ack      = 1'b0;
    unique case (state_q)
      IDLE: begin
        fm_block      = ebox_block;
        fm_adr        = ebox_adr;
        // A forced diagnostic acceptance kills the EBOX write; EBOX retries.
        fm_write00_17 = ebox_req & ebox_wr_l & ~force_acc;
        fm_write18_35 = ebox_req & ebox_wr_r & ~force_acc;
        if (accept) begin
          cmd_d   = '{write: diag_write, block: diag_block, adr: diag_adr};
          state_d = HOLD;
        end
      end
      HOLD: state_d = cmd_q.write ? LDAR : RDAD;
      LDAR: begin
        ar_load_ebus = AR_SEL_EBUS;
        state_d      = WRFM;
      end
      WRFM: begin
        fm_write00_17 = 1'b1;
        fm_write18_35 = 1'b1;
        state_d       = DONE;
      end
      RDAD: begin
        ad_sel_fm    = 1'b1;
        ad_to_ebus_l = 1'b1;
        ad_to_ebus_r = 1'b1;
        rdata_d      = ebus_data;
        state_d      = DONE;
      end
      DONE: begin
        diag_ack = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // No FM write may land while CROBAR is asserted.
    if (CROBAR) begin
      fm_write00_17 = 1'b0;
      fm_write18_35 = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
    end
  end

  assign ebox_hold  = ~idle;
  assign diag_busy  = ~idle;
  assign diag_rdata = rdata_q;

endmodule

// File: tb/tb_fm_diag_arb.sv
// Directed table-driven bench for fm_diag_arb (STARVE_LIMIT = 3), plus a
// direct check of the saturating fm_starve_ctr.
module tb_fm_diag_arb;

  logic        clk = 1'b0;
  logic        CROBAR = 1'b1;
  logic        ebox_req = 0, ebox_wr_l = 0, ebox_wr_r = 0;
  logic [2:0]  ebox_block = 0;
  logic [3:0]  ebox_adr = 0;
  logic        ebox_hold;
  logic        diag_req = 0, diag_write = 0;
  logic [2:0]  diag_block = 0;
  logic [3:0]  diag_adr = 0;
  logic        diag_ack, diag_busy;
  logic [0:35] diag_rdata;
  logic [0:35] ebus_data = 0;
  logic [2:0]  fm_block;
  logic [3:0]  fm_adr;
  logic        fm_write00_17, fm_write18_35, ar_load_ebus, ad_sel_fm;
  logic        ad_to_ebus_l, ad_to_ebus_r;

  logic ct_rst = 1'b1, ct_clr = 1'b0, ct_inc = 1'b0, ct_at;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fm_diag_arb #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .CROBAR(CROBAR),
    .ebox_req(ebox_req), .ebox_block(ebox_block), .ebox_adr(ebox_adr),
    .ebox_wr_l(ebox_wr_l), .ebox_wr_r(ebox_wr_r), .ebox_hold(ebox_hold),
    .diag_req(diag_req), .diag_write(diag_write), .diag_block(diag_block),
    .diag_adr(diag_adr), .diag_ack(diag_ack), .diag_busy(diag_busy),
    .diag_rdata(diag_rdata), .ebus_data(ebus_data),
    .fm_block(fm_block), .fm_adr(fm_adr),
    .fm_write00_17(fm_write00_17), .fm_write18_35(fm_write18_35),
    .ar_load_ebus(ar_load_ebus), .ad_sel_fm(ad_sel_fm),
    .ad_to_ebus_l(ad_to_ebus_l), .ad_to_ebus_r(ad_to_ebus_r)
  );

  fm_starve_ctr #(.LIMIT(3)) u_ctr (
    .clk(clk), .rst(ct_rst), .clr(ct_clr), .inc(ct_inc), .at_limit(ct_at)
  );

  typedef struct {
    string       name;
    logic        crob;
    logic        ereq;
    logic [2:0]  eblk;
    logic [3:0]  eadr;
    logic [1:0]  ewr;   // {wr_l, wr_r}
    logic        dreq, dwr;
    logic [2:0]  dblk;
    logic [3:0]  dadr;
    logic [35:0] ebus;
    logic [8:0]  ctrl;  // {hold, ack, busy, w00, w18, arld, adsel, adl, adr}
    logic [2:0]  fblk;
    logic [3:0]  fadr;
    logic [35:0] rdata;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic er, input logic [2:0] eb,
      input logic [3:0] ea, input logic [1:0] ew, input logic dr, input logic dw,
      input logic [2:0] db, input logic [3:0] da, input logic [35:0] ed,
      input logic [8:0] ct, input logic [2:0] fb, input logic [3:0] fa,
      input logic [35:0] rd);
    vec_t v;
    v.name = nm; v.crob = 1'b0; v.ereq = er; v.eblk = eb; v.eadr = ea; v.ewr = ew;
    v.dreq = dr; v.dwr = dw; v.dblk = db; v.dadr = da; v.ebus = ed;
    v.ctrl = ct; v.fblk = fb; v.fadr = fa; v.rdata = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge, check mid-cycle.
  task automatic apply(input vec_t v);
    @(posedge clk); #1;
    CROBAR = v.crob;
    ebox_req = v.ereq; ebox_block = v.eblk; ebox_adr = v.eadr;
    ebox_wr_l = v.ewr[1]; ebox_wr_r = v.ewr[0];
    diag_req = v.dreq; diag_write = v.dwr; diag_block = v.dblk; diag_adr = v.dadr;
    ebus_data = v.ebus;
    #4;
    chk({v.name, ":ctrl"},
        36'({ebox_hold, diag_ack, diag_busy, fm_write00_17, fm_write18_35,
             ar_load_ebus, ad_sel_fm, ad_to_ebus_l, ad_to_ebus_r}), 36'(v.ctrl));
    chk({v.name, ":fm"}, 36'({fm_block, fm_adr}), 36'({v.fblk, v.fadr}));
    chk({v.name, ":rdata"}, diag_rdata, v.rdata);
  endtask

  task automatic ct_step(input string nm, input logic clr, input logic inc, input logic exp);
    ct_clr = clr; ct_inc = inc;
    @(posedge clk); #1;
    chk(nm, 36'(ct_at), 36'(exp));
  endtask

  localparam logic [35:0] E1 = 36'h123456789;
  localparam logic [35:0] R1 = 36'h555555555;
  localparam logic [35:0] E2 = 36'h0fedcba98;
  localparam logic [35:0] RA = 36'h00000aaaa;
  localparam logic [35:0] RF = 36'hfffffffff;

  vec_t tbl[20];
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk("pass_both", 1, 3'd0, 4'd7, 2'b11, 0, 0, 0, 0, 0, 9'b000_11_0000, 0, 7, 0);
    tbl[1]  = mk("pass_left", 1, 3'd3, 4'd9, 2'b10, 0, 0, 0, 0, 0, 9'b000_10_0000, 3, 9, 0);
    tbl[2]  = mk("no_req",    0, 3'd4, 4'd2, 2'b11, 0, 0, 0, 0, 0, 9'b000_00_0000, 4, 2, 0);
    tbl[3]  = mk("wr_acc",    0, 0, 0, 0, 1, 1, 3'd2, 4'd5, E1, 9'b000_00_0000, 0, 0, 0);
    tbl[4]  = mk("wr_hold",   1, 3'd6, 4'd15, 2'b11, 0, 0, 0, 0, E1, 9'b101_00_0000, 2, 5, 0);
    tbl[5]  = mk("wr_ldar",   0, 0, 0, 0, 0, 0, 0, 0, E1, 9'b101_00_1000, 2, 5, 0);
    tbl[6]  = mk("wr_wrfm",   0, 0, 0, 0, 0, 0, 0, 0, E1, 9'b101_11_0000, 2, 5, 0);
    tbl[7]  = mk("wr_done",   0, 0, 0, 0, 0, 0, 0, 0, E1, 9'b111_00_0000, 2, 5, 0);
    tbl[8]  = mk("wr_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0,  9'b000_00_0000, 0, 0, 0);
    tbl[9]  = mk("rd_acc",    0, 0, 0, 0, 1, 0, 3'd1, 4'd7, 0, 9'b000_00_0000, 0, 0, 0);
    tbl[10] = mk("rd_hold",   0, 0, 0, 0, 1, 1, 3'd6, 4'd3, 0, 9'b101_00_0000, 1, 7, 0);
    tbl[11] = mk("rd_rdad",   0, 0, 0, 0, 0, 0, 0, 0, R1, 9'b101_00_0111, 1, 7, 0);
    tbl[12] = mk("rd_done",   0, 0, 0, 0, 0, 0, 0, 0, 0,  9'b111_00_0000, 1, 7, R1);
    tbl[13] = mk("rd_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0,  9'b000_00_0000, 0, 0, R1);
    tbl[14] = mk("wr2_acc",   0, 0, 0, 0, 1, 1, 3'd0, 4'd1, E2, 9'b000_00_0000, 0, 0, R1);
    tbl[15] = mk("wr2_hold",  0, 0, 0, 0, 0, 0, 0, 0, E2, 9'b101_00_0000, 0, 1, R1);
    tbl[16] = mk("wr2_ldar",  0, 0, 0, 0, 0, 0, 0, 0, E2, 9'b101_00_1000, 0, 1, R1);
    tbl[17] = mk("wr2_wrfm",  0, 0, 0, 0, 0, 0, 0, 0, E2, 9'b101_11_0000, 0, 1, R1);
    tbl[18] = mk("wr2_done",  0, 0, 0, 0, 0, 0, 0, 0, E2, 9'b111_00_0000, 0, 1, R1);
    tbl[19] = mk("wr2_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0,  9'b000_00_0000, 0, 0, R1);

    // Reset: held for a few edges, outputs checked while still asserted.
    v = mk("in_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b0, 0, 0, 0);
    v.crob = 1'b1;
    repeat (2) apply(v);
    for (int i = 0; i < 10; i++)
      apply(mk("idle_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b0, 0, 0, 0));

    for (int i = 0; i < 20; i++) apply(tbl[i]);

    // CROBAR in LDAR aborts: no ack, no FM write, hold drops, rdata cleared.
    apply(mk("crb_acc",  0, 0, 0, 0, 1, 1, 3'd7, 4'd12, E2, 9'b000_00_0000, 0, 0, R1));
    apply(mk("crb_hold", 0, 0, 0, 0, 0, 0, 0, 0, E2, 9'b101_00_0000, 7, 12, R1));
    v = mk("crb_ldar",   0, 0, 0, 0, 0, 0, 0, 0, E2, 9'b101_00_1000, 7, 12, R1);
    v.crob = 1'b1;
    apply(v);
    for (int i = 0; i < 3; i++)
      apply(mk("crb_after", 0, 0, 0, 0, 0, 0, 0, 0, E2, 9'b000_00_0000, 0, 0, 0));

    // Back-to-back: diag_req held through ack, re-accepted in the IDLE after DONE.
    apply(mk("b2b_acc1", 0, 0, 0, 0, 1, 0, 3'd0, 4'd3, 0,  9'b000_00_0000, 0, 0, 0));
    apply(mk("b2b_hold", 0, 0, 0, 0, 1, 0, 3'd0, 4'd3, 0,  9'b101_00_0000, 0, 3, 0));
    apply(mk("b2b_rdad", 0, 0, 0, 0, 1, 0, 3'd0, 4'd3, RA, 9'b101_00_0111, 0, 3, 0));
    apply(mk("b2b_done", 0, 0, 0, 0, 1, 0, 3'd0, 4'd3, 0,  9'b111_00_0000, 0, 3, RA));
    apply(mk("b2b_acc2", 0, 0, 0, 0, 1, 0, 3'd5, 4'd10, 0, 9'b000_00_0000, 0, 0, RA));
    apply(mk("b2b_hld2", 0, 0, 0, 0, 0, 0, 0, 0, 0,  9'b101_00_0000, 5, 10, RA));
    apply(mk("b2b_rda2", 0, 0, 0, 0, 0, 0, 0, 0, RF, 9'b101_00_0111, 5, 10, RA));
    apply(mk("b2b_dn2",  0, 0, 0, 0, 0, 0, 0, 0, 0,  9'b111_00_0000, 5, 10, RF));
    apply(mk("b2b_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0,  9'b000_00_0000, 0, 0, RF));

    // Contention: EBOX and diagnostic request together.
`ifdef FM_DIAG_STARVE_EN
    for (int i = 0; i < 3; i++)
      apply(mk("cont_lose", 1, 3'd1, 4'd4, 2'b11, 1, 1, 3'd3, 4'd6, 0, 9'b000_11_0000, 1, 4, RF));
    apply(mk("cont_force", 1, 3'd1, 4'd4, 2'b11, 1, 1, 3'd3, 4'd6, 0, 9'b000_00_0000, 1, 4, RF));
    apply(mk("cont_hold",  0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b101_00_0000, 3, 6, RF));
    apply(mk("cont_ldar",  0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b101_00_1000, 3, 6, RF));
    apply(mk("cont_wrfm",  0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b101_11_0000, 3, 6, RF));
    apply(mk("cont_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b111_00_0000, 3, 6, RF));
`else
    for (int i = 0; i < 8; i++)
      apply(mk("cont_ebox", 1, 3'd1, 4'd4, 2'b11, 1, 1, 3'd3, 4'd6, 0, 9'b000_11_0000, 1, 4, RF));
`endif
    apply(mk("cont_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b000_00_0000, 0, 0, RF));

    // Saturating counter, LIMIT = 3.
    ct_rst = 1'b1;
    ct_step("ct_reset", 0, 0, 0);
    ct_rst = 1'b0;
    ct_step("ct_inc1", 0, 1, 0);
    ct_step("ct_inc2", 0, 1, 0);
    ct_step("ct_inc3", 0, 1, 1);
    for (int i = 0; i < 5; i++) ct_step("ct_sat", 0, 1, 1);
    ct_step("ct_clr", 1, 0, 0);
    ct_step("ct_clr_wins", 1, 1, 0);
    ct_step("ct_re1", 0, 1, 0);
    ct_step("ct_re2", 0, 1, 0);
    ct_step("ct_re3", 0, 1, 1);
    ct_step("ct_hold", 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
